// File: rtl/mii_pkg.sv
// Shared types and default byte constants for the MII receive path.
package mii_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] len_t;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_e;

  localparam byte_t PRE_BYTE_DEF = 8'h55;
  localparam byte_t SFD_BYTE_DEF = 8'hD5;

endpackage

// File: rtl/mii_rx_hold.sv
// One-byte hold register: delays each data byte by one byte-time so the
// last byte of a frame can be tagged with eof once the end is known.
module mii_rx_hold
  import mii_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,    // outside a frame: keep the register empty
  input  logic  load_i,   // new byte; emits the held byte first if full
  input  logic  flush_i,  // emit the held byte as the frame's last
  input  logic  err_i,    // error tag carried with a flush
  input  byte_t d_i,
  output logic  full_o,
  output logic  vld_o,
  output logic  sof_o,
  output logic  eof_o,
  output logic  err_o,
  output byte_t data_o
);

  byte_t hold_q, data_q;
  logic  full_q, first_q, vld_q, sof_q, eof_q, err_q;

  // Hold/emit sequencing; strobes default low so they are single-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q  <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      first_q <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      err_q <= 1'b0;
      if (clr_i) begin
        full_q  <= 1'b0;
        first_q <= 1'b0;
      end else if (flush_i) begin
        if (full_q) begin
          vld_q  <= 1'b1;
          sof_q  <= first_q;
          eof_q  <= 1'b1;
          err_q  <= err_i;
          data_q <= hold_q;
        end
        full_q <= 1'b0;
      end else if (load_i) begin
        if (full_q) begin
          vld_q  <= 1'b1;
          sof_q  <= first_q;
          data_q <= hold_q;
        end
        hold_q  <= d_i;
        full_q  <= 1'b1;
        first_q <= !full_q;  // only a byte loaded into an empty register opens the frame
      end
    end
  end

  assign full_o = full_q;
  assign vld_o  = vld_q;
  assign sof_o  = sof_q;
  assign eof_o  = eof_q;
  assign err_o  = err_q;
  assign data_o = data_q;

endmodule

// File: rtl/mii_rx_framer.sv
// Receive-frame controller: preamble/SFD strip, length limits, byte stream
// with sof/eof/err markers, per-frame length and frame/error statistics.
module mii_rx_framer
  import mii_pkg::*;
#(
  parameter int    PRE_MIN  = 2,
  parameter byte_t PRE_BYTE = PRE_BYTE_DEF,
  parameter byte_t SFD_BYTE = SFD_BYTE_DEF,
  parameter int    MIN_LEN  = 64,
  parameter int    MAX_LEN  = 1518
) (
  input  logic        mii_clk,
  input  logic        reset_n,
  input  logic        mii_en,
  input  logic        byte_rdy,
  input  logic [7:0]  byte_d,
  output logic        core_rst,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [15:0] rx_len,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  state_e state_q;
  logic   core_rst_q, pend_q;
  logic [7:0] pre_cnt_q;
  len_t   len_q, rx_len_q, frame_cnt_q, err_cnt_q;

  logic at_max, in_data, hold_full;
  logic load_d, flush_d, err_d;

  assign at_max  = (len_q == len_t'(MAX_LEN));
  assign in_data = (state_q == DATA);
  // pend_q: mii_en has dropped; the held byte goes out as eof next cycle.
  assign load_d  = in_data && !pend_q && byte_rdy && !at_max;
  assign flush_d = in_data && (pend_q || (byte_rdy && at_max));
  assign err_d   = pend_q ? (len_q < len_t'(MIN_LEN)) : 1'b1;

  mii_rx_hold u_hold (
    .clk_i   (mii_clk),
    .rst_ni  (reset_n),
    .clr_i   (!in_data),
    .load_i  (load_d),
    .flush_i (flush_d),
    .err_i   (err_d),
    .d_i     (byte_d),
    .full_o  (hold_full),
    .vld_o   (rx_valid),
    .sof_o   (rx_sof),
    .eof_o   (rx_eof),
    .err_o   (rx_err),
    .data_o  (rx_data)
  );

  // Frame FSM with length, preamble and statistic counters.
  always_ff @(posedge mii_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      core_rst_q  <= 1'b1;
      pend_q      <= 1'b0;
      pre_cnt_q   <= '0;
      len_q       <= '0;
      rx_len_q    <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_cnt_q <= '0;
          if (mii_en) begin
            state_q    <= PRE;
            core_rst_q <= 1'b0;
          end
        end
        PRE: begin
          if (!mii_en) begin
            state_q    <= IDLE;
            core_rst_q <= 1'b1;
          end else if (byte_rdy) begin
            if (byte_d == PRE_BYTE) begin
              if (pre_cnt_q != 8'hFF) pre_cnt_q <= pre_cnt_q + 8'd1;
            end else if (byte_d == SFD_BYTE && pre_cnt_q >= 8'(PRE_MIN)) begin
              state_q <= DATA;
              len_q   <= '0;
              pend_q  <= 1'b0;
            end else begin
              err_cnt_q  <= err_cnt_q + 16'd1;
              state_q    <= DROP;
              core_rst_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (pend_q) begin
            pend_q     <= 1'b0;
            rx_len_q   <= len_q;
            if (len_q < len_t'(MIN_LEN)) err_cnt_q <= err_cnt_q + 16'd1;
            else                         frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q    <= IDLE;
            core_rst_q <= 1'b1;
          end else if (byte_rdy && at_max) begin
            // Truncation: the new byte is dropped, the rest of the frame is ignored.
            rx_len_q   <= len_q;
            err_cnt_q  <= err_cnt_q + 16'd1;
            state_q    <= DROP;
            core_rst_q <= 1'b1;
          end else begin
            if (byte_rdy) len_q <= len_q + 16'd1;
            if (!mii_en) begin
              if (byte_rdy || hold_full) begin
                pend_q <= 1'b1;
              end else begin
                err_cnt_q  <= err_cnt_q + 16'd1;
                state_q    <= IDLE;
                core_rst_q <= 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (!mii_en) state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          core_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign rx_len    = rx_len_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: good, runt, oversize, preamble errors,
// length boundaries, same-edge end of frame and reset mid-frame.
module tb_mii_rx_framer;

  logic        mii_clk = 1'b0;
  logic        reset_n;
  logic        mii_en;
  logic        byte_rdy;
  logic [7:0]  byte_d;
  logic        core_rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [15:0] rx_len;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // stream monitor state
  int vcnt, sofcnt, eofcnt, bothcnt, seq_bad, stray, pos;
  logic [7:0]  sof_data, eof_data;
  logic        eof_err;
  logic [15:0] eof_len;
  logic        rst_before_drop;

  mii_rx_framer dut (
    .mii_clk   (mii_clk),
    .reset_n   (reset_n),
    .mii_en    (mii_en),
    .byte_rdy  (byte_rdy),
    .byte_d    (byte_d),
    .core_rst  (core_rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_err    (rx_err),
    .rx_len    (rx_len),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 mii_clk = ~mii_clk;

  // Collect the output stream away from the active edge; data bytes are
  // expected to count up from 0 starting at each sof.
  always @(negedge mii_clk) begin
    if (rx_valid) begin
      vcnt++;
      if (rx_sof) begin
        sofcnt++;
        sof_data = rx_data;
        pos = 0;
      end
      if (rx_data !== 8'(pos)) seq_bad++;
      pos++;
      if (rx_eof) begin
        eofcnt++;
        eof_data = rx_data;
        eof_err  = rx_err;
        eof_len  = rx_len;
        if (rx_sof) bothcnt++;
      end
    end else if (rx_sof || rx_eof || rx_err) begin
      stray++;
    end
  end

  task automatic tick();
    @(posedge mii_clk);
    #1;
  endtask

  task automatic clr_mon();
    vcnt = 0; sofcnt = 0; eofcnt = 0; bothcnt = 0; seq_bad = 0; stray = 0; pos = 0;
    sof_data = 8'h00; eof_data = 8'h00; eof_err = 1'b0; eof_len = 16'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic drop_en);
    byte_rdy = 1'b1;
    byte_d   = b;
    if (drop_en) mii_en = 1'b0;
    tick();
    byte_rdy = 1'b0;
    tick();
  endtask

  // npre x 55, SFD, ndata bytes 0,1,2..; optionally drop mii_en with the last byte.
  task automatic frame(input int npre, input int ndata, input logic same_edge);
    clr_mon();
    mii_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < npre; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < ndata; i++) send_byte(8'(i), same_edge && (i == ndata - 1));
    rst_before_drop = core_rst;
    mii_en = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mii_en = 1'b0; byte_rdy = 1'b0; byte_d = 8'h00;
    clr_mon();
    repeat (3) tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b exp 1", core_rst); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %0b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %0h exp 0", rx_data); end
    checks++; if (rx_len !== 16'd0) begin errors++; $display("FAIL reset_rx_len got %0d exp 0", rx_len); end
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnts got %0d/%0d exp 0/0", frame_cnt, err_cnt); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_good();
    frame(7, 64, 1'b0);
    checks++; if (vcnt !== 64) begin errors++; $display("FAIL good_vcnt got %0d exp 64", vcnt); end
    checks++; if (sofcnt !== 1 || sof_data !== 8'h00) begin errors++; $display("FAIL good_sof got %0d/%0h exp 1/00", sofcnt, sof_data); end
    checks++; if (eofcnt !== 1 || eof_data !== 8'h3F) begin errors++; $display("FAIL good_eof got %0d/%0h exp 1/3f", eofcnt, eof_data); end
    checks++; if (eof_err !== 1'b0) begin errors++; $display("FAIL good_err got %0b exp 0", eof_err); end
    checks++; if (eof_len !== 16'd64 || rx_len !== 16'd64) begin errors++; $display("FAIL good_len got %0d/%0d exp 64", eof_len, rx_len); end
    checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin errors++; $display("FAIL good_cnts got %0d/%0d exp 1/0", frame_cnt, err_cnt); end
    checks++; if (seq_bad !== 0 || stray !== 0) begin errors++; $display("FAIL good_stream got %0d/%0d exp 0/0", seq_bad, stray); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL good_idle_rst got %0b exp 1", core_rst); end
  endtask

  task automatic test_runt();
    frame(7, 10, 1'b0);
    checks++; if (vcnt !== 10) begin errors++; $display("FAIL runt_vcnt got %0d exp 10", vcnt); end
    checks++; if (eofcnt !== 1 || eof_data !== 8'h09 || eof_err !== 1'b1) begin errors++; $display("FAIL runt_eof got %0d/%0h/%0b exp 1/09/1", eofcnt, eof_data, eof_err); end
    checks++; if (rx_len !== 16'd10) begin errors++; $display("FAIL runt_len got %0d exp 10", rx_len); end
    checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd1) begin errors++; $display("FAIL runt_cnts got %0d/%0d exp 1/1", frame_cnt, err_cnt); end
  endtask

  task automatic test_oversize();
    frame(7, 1600, 1'b0);
    checks++; if (vcnt !== 1518) begin errors++; $display("FAIL over_vcnt got %0d exp 1518", vcnt); end
    checks++; if (eofcnt !== 1 || eof_data !== 8'hED || eof_err !== 1'b1) begin errors++; $display("FAIL over_eof got %0d/%0h/%0b exp 1/ed/1", eofcnt, eof_data, eof_err); end
    checks++; if (eof_len !== 16'd1518) begin errors++; $display("FAIL over_len got %0d exp 1518", eof_len); end
    checks++; if (rst_before_drop !== 1'b1) begin errors++; $display("FAIL over_core_rst got %0b exp 1", rst_before_drop); end
    checks++; if (frame_cnt !== 16'd1 || err_cnt !== 16'd2) begin errors++; $display("FAIL over_cnts got %0d/%0d exp 1/2", frame_cnt, err_cnt); end
    checks++; if (seq_bad !== 0) begin errors++; $display("FAIL over_stream got %0d exp 0", seq_bad); end
  endtask

  task automatic test_pre_err();
    clr_mon();
    mii_en = 1'b1;
    tick();
    tick();
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL prerr_core_rst got %0b exp 1", core_rst); end
    mii_en = 1'b0;
    repeat (4) tick();
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL prerr_vcnt got %0d exp 0", vcnt); end
    checks++; if (err_cnt !== 16'd3) begin errors++; $display("FAIL prerr_err_cnt got %0d exp 3", err_cnt); end
    frame(7, 64, 1'b0);
    checks++; if (vcnt !== 64 || eof_err !== 1'b0) begin errors++; $display("FAIL prerr_next got %0d/%0b exp 64/0", vcnt, eof_err); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL prerr_frame_cnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_short_pre();
    frame(1, 64, 1'b0);
    checks++; if (vcnt !== 0 || err_cnt !== 16'd4) begin errors++; $display("FAIL shortpre_drop got %0d/%0d exp 0/4", vcnt, err_cnt); end
    frame(2, 64, 1'b0);
    checks++; if (vcnt !== 64 || frame_cnt !== 16'd3) begin errors++; $display("FAIL shortpre_accept got %0d/%0d exp 64/3", vcnt, frame_cnt); end
  endtask

  task automatic test_bounds();
    frame(7, 63, 1'b0);
    checks++; if (vcnt !== 63 || eof_err !== 1'b1 || err_cnt !== 16'd5) begin errors++; $display("FAIL len63 got %0d/%0b/%0d exp 63/1/5", vcnt, eof_err, err_cnt); end
    frame(7, 1, 1'b0);
    checks++; if (bothcnt !== 1 || vcnt !== 1 || rx_len !== 16'd1) begin errors++; $display("FAIL len1 got %0d/%0d/%0d exp 1/1/1", bothcnt, vcnt, rx_len); end
    checks++; if (eof_err !== 1'b1 || err_cnt !== 16'd6) begin errors++; $display("FAIL len1_err got %0b/%0d exp 1/6", eof_err, err_cnt); end
    frame(7, 0, 1'b0);
    checks++; if (vcnt !== 0 || stray !== 0 || err_cnt !== 16'd7) begin errors++; $display("FAIL len0 got %0d/%0d/%0d exp 0/0/7", vcnt, stray, err_cnt); end
    frame(7, 1518, 1'b0);
    checks++; if (vcnt !== 1518 || eof_err !== 1'b0 || eof_data !== 8'hED) begin errors++; $display("FAIL len1518 got %0d/%0b/%0h exp 1518/0/ed", vcnt, eof_err, eof_data); end
    checks++; if (rx_len !== 16'd1518 || frame_cnt !== 16'd4) begin errors++; $display("FAIL len1518_cnt got %0d/%0d exp 1518/4", rx_len, frame_cnt); end
  endtask

  task automatic test_same_edge();
    frame(7, 70, 1'b1);
    checks++; if (vcnt !== 70 || eofcnt !== 1 || eof_data !== 8'h45) begin errors++; $display("FAIL sameedge got %0d/%0d/%0h exp 70/1/45", vcnt, eofcnt, eof_data); end
    checks++; if (rx_len !== 16'd70 || frame_cnt !== 16'd5 || err_cnt !== 16'd7) begin errors++; $display("FAIL sameedge_cnt got %0d/%0d/%0d exp 70/5/7", rx_len, frame_cnt, err_cnt); end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    mii_en = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) send_byte(8'(i), 1'b0);
    reset_n = 1'b0;
    #2;
    checks++; if (rx_valid !== 1'b0 || core_rst !== 1'b1 || rx_len !== 16'd0) begin errors++; $display("FAIL rstmid_out got %0b/%0b/%0d exp 0/1/0", rx_valid, core_rst, rx_len); end
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnts got %0d/%0d exp 0/0", frame_cnt, err_cnt); end
    tick();
    mii_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    checks++; if (vcnt !== 19 || eofcnt !== 0) begin errors++; $display("FAIL rstmid_partial got %0d/%0d exp 19/0", vcnt, eofcnt); end
    frame(7, 64, 1'b0);
    checks++; if (frame_cnt !== 16'd1 || rx_len !== 16'd64 || err_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_next got %0d/%0d/%0d exp 1/64/0", frame_cnt, rx_len, err_cnt); end
    checks++; if (vcnt !== 64 || eofcnt !== 1 || seq_bad !== 0) begin errors++; $display("FAIL rstmid_stream got %0d/%0d/%0d exp 64/1/0", vcnt, eofcnt, seq_bad); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_runt();
    test_oversize();
    test_pre_err();
    test_short_pre();
    test_bounds();
    test_same_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
